// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
// Imported by the divider top, its step sub-module and the bench.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int LATENCY   = DIV_WIDTH + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    FIX  = ST_FIX
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor magnitude and keep or restore.
module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;

  assign sh   = {rem, bit_in};
  assign diff = sh - {2'b00, dsr};

  // a clear top bit means the trial subtraction did not borrow
  assign q_bit    = ~diff[WIDTH+1];
  assign rem_next = q_bit ? diff[WIDTH:0] : sh[WIDTH:0];

endmodule

// File: rtl/seq_div_signed.sv
// Multi-cycle signed divider: one restoring step per clock,
// truncating toward zero, with a two-edge divide-by-zero early out.
module seq_div_signed
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] dvd, dvd_n;
  logic [WIDTH-1:0] dsr, dsr_n;
  logic [WIDTH:0]   prem, prem_n;
  logic             sq, sq_n;
  logic             sr, sr_n;
  logic             zflag, zflag_n;
  logic             busy_n, done_n, dz_n;
  logic [WIDTH-1:0] quo_n, rem_n;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] r_mag;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (prem),
    .bit_in  (dvd[WIDTH-1]),
    .dsr     (dsr),
    .rem_next(step_rem),
    .q_bit   (step_q)
  );

  // dvd shifts the dividend magnitude out and the quotient in;
  // on the div0 path it still holds |dividend|
  assign r_mag = zflag ? dvd : prem[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      prem        <= '0;
      sq          <= 1'b0;
      sr          <= 1'b0;
      zflag       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      dvd         <= dvd_n;
      dsr         <= dsr_n;
      prem        <= prem_n;
      sq          <= sq_n;
      sr          <= sr_n;
      zflag       <= zflag_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      div_by_zero <= dz_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dvd_n   = dvd;
    dsr_n   = dsr;
    prem_n  = prem;
    sq_n    = sq;
    sr_n    = sr;
    zflag_n = zflag;
    busy_n  = busy;
    done_n  = 1'b0;
    quo_n   = quotient;
    rem_n   = remainder;
    dz_n    = div_by_zero;
    unique case (state)
      IDLE: begin
        // the done cycle is also IDLE; a start there is dropped
        if (start && !done) begin
          dvd_n   = mag(dividend);
          dsr_n   = mag(divisor);
          sq_n    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_n    = dividend[WIDTH-1];
          prem_n  = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          zflag_n = (divisor == '0);
          state_n = (divisor == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        prem_n = step_rem;
        dvd_n  = {dvd[WIDTH-2:0], step_q};
        cnt_n  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_n = FIX;
        end
      end
      FIX: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
        rem_n   = sr ? -r_mag : r_mag;
        if (zflag) begin
          quo_n = {WIDTH{1'b1}};
          dz_n  = 1'b1;
        end else begin
          quo_n = sq ? -dvd : dvd;
          dz_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
